// File: rtl/systolic_mac_array.sv
// Output-stationary N x N systolic matrix-multiply engine: streams A columns / B rows,
// accumulates C = A*B in a PE grid, then drains C row-major over a valid/ready port.
module systolic_mac_array #(
  parameter int N      = 2,
  parameter int DW     = 8,
  parameter int ACC_W  = 18,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   a_col,
  input  logic [N*DW-1:0]   b_row,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CW = $clog2(2*N);
  localparam int IW = $clog2(N*N);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N-2);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N*N-1);

  typedef enum logic [1:0] {IDLE = 2'd0, FEED = 2'd1, DRAIN = 2'd2, READ = 2'd3} state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [IW-1:0]    idx_r, idx_nx_s;
  logic             in_ready_r, busy_r, out_valid_r, out_last_r;
  logic [ACC_W-1:0] out_data_r;
  logic             accept_s, hs_s, clear_s;

  logic [DW-1:0]    a_skew_s [N];
  logic             av_skew_s [N];
  logic [DW-1:0]    b_skew_s [N];
  logic             bv_skew_s [N];
  logic [DW-1:0]    a_hop_s  [N][N-1];
  logic             av_hop_s [N][N-1];
  logic [DW-1:0]    b_hop_s  [N-1][N];
  logic             bv_hop_s [N-1][N];
  logic [ACC_W-1:0] acc_s    [N*N];

  // DW x DW product, widened to the accumulator with the operand signedness.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] ax;
    logic [2*DW-1:0] bx;
    logic [2*DW-1:0] p;
    if (SIGNED) begin
      ax = {{DW{a[DW-1]}}, a};
      bx = {{DW{b[DW-1]}}, b};
    end else begin
      ax = {{DW{1'b0}}, a};
      bx = {{DW{1'b0}}, b};
    end
    p = ax * bx;
    if (SIGNED) mul_ext = ACC_W'($signed(p));
    else        mul_ext = ACC_W'(p);
  endfunction

  assign accept_s = in_valid && in_ready_r;
  assign hs_s     = (state_r == READ) && out_valid_r && out_ready;
  assign clear_s  = hs_s && out_last_r;
  assign idx_nx_s = idx_r + IW'(1'b1);

  assign in_ready  = in_ready_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_data  = out_data_r;

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [DW-1:0] a_sk_r  [0:i];
    logic          av_sk_r [0:i];
    logic [DW-1:0] b_sk_r  [0:i];
    logic          bv_sk_r [0:i];

    // Lane i passes through i+1 registers so the wavefront reaches PE(i,0)/PE(0,i) skewed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) begin
          a_sk_r[s] <= '0; av_sk_r[s] <= 1'b0; b_sk_r[s] <= '0; bv_sk_r[s] <= 1'b0;
        end
      end else if (clear_s) begin
        for (int s = 0; s <= i; s++) begin
          a_sk_r[s] <= '0; av_sk_r[s] <= 1'b0; b_sk_r[s] <= '0; bv_sk_r[s] <= 1'b0;
        end
      end else begin
        a_sk_r[0]  <= accept_s ? a_col[i*DW +: DW] : '0;
        av_sk_r[0] <= accept_s;
        b_sk_r[0]  <= accept_s ? b_row[i*DW +: DW] : '0;
        bv_sk_r[0] <= accept_s;
        for (int s = 1; s <= i; s++) begin
          a_sk_r[s] <= a_sk_r[s-1]; av_sk_r[s] <= av_sk_r[s-1];
          b_sk_r[s] <= b_sk_r[s-1]; bv_sk_r[s] <= bv_sk_r[s-1];
        end
      end
    end

    assign a_skew_s[i]  = a_sk_r[i];
    assign av_skew_s[i] = av_sk_r[i];
    assign b_skew_s[i]  = b_sk_r[i];
    assign bv_skew_s[i] = bv_sk_r[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic [ACC_W-1:0] acc_r;
      logic [DW-1:0]    a_s, b_s;
      logic             av_s, bv_s;

      if (j == 0) begin : g_a_edge
        assign a_s = a_skew_s[i];  assign av_s = av_skew_s[i];
      end else begin : g_a_hop
        assign a_s = a_hop_s[i][j-1]; assign av_s = av_hop_s[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_s = b_skew_s[j];  assign bv_s = bv_skew_s[j];
      end else begin : g_b_hop
        assign b_s = b_hop_s[i-1][j]; assign bv_s = bv_hop_s[i-1][j];
      end

      // Accumulate only on valid operand pairs; bubbles leave the sum untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 acc_r <= '0;
        else if (clear_s)           acc_r <= '0;
        else if (av_s && bv_s)      acc_r <= acc_r + mul_ext(a_s, b_s);
        else                        acc_r <= acc_r;
      end
      assign acc_s[i*N+j] = acc_r;

      if (j < N-1) begin : g_pass_a
        logic [DW-1:0] a_r;
        logic          av_r;
        // One-hop register carrying a (and its valid) to the right neighbour.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       begin a_r <= '0;  av_r <= 1'b0; end
          else if (clear_s) begin a_r <= '0;  av_r <= 1'b0; end
          else              begin a_r <= a_s; av_r <= av_s; end
        end
        assign a_hop_s[i][j]  = a_r;
        assign av_hop_s[i][j] = av_r;
      end
      if (i < N-1) begin : g_pass_b
        logic [DW-1:0] b_r;
        logic          bv_r;
        // One-hop register carrying b (and its valid) to the neighbour below.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)       begin b_r <= '0;  bv_r <= 1'b0; end
          else if (clear_s) begin b_r <= '0;  bv_r <= 1'b0; end
          else              begin b_r <= b_s; bv_r <= bv_s; end
        end
        assign b_hop_s[i][j]  = b_r;
        assign bv_hop_s[i][j] = bv_r;
      end
    end
  end

  // Next-state logic; DRAIN waits for the last wavefront to reach PE(N-1,N-1).
  always_comb begin
    state_s = state_r;
    cnt_s   = '0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = in_last ? DRAIN : FEED;
        else          state_s = IDLE;
      end
      FEED: begin
        if (accept_s && in_last) state_s = DRAIN;
        else                     state_s = FEED;
      end
      DRAIN: begin
        if (cnt_r == DRAIN_LAST) state_s = READ;
        else                     cnt_s   = cnt_r + CW'(1'b1);
      end
      READ: begin
        if (clear_s) state_s = IDLE;
        else         state_s = READ;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, handshake flags and the row-major result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      in_ready_r <= (state_s == IDLE) || (state_s == FEED);
      busy_r     <= (state_s != IDLE);
      if ((state_r == DRAIN) && (state_s == READ)) begin
        out_valid_r <= 1'b1;
        out_data_r  <= acc_s[0];
        idx_r       <= '0;
        out_last_r  <= 1'b0;
      end else if (hs_s && out_last_r) begin
        out_valid_r <= 1'b0;
        out_data_r  <= '0;
        idx_r       <= '0;
        out_last_r  <= 1'b0;
      end else if (hs_s) begin
        idx_r      <= idx_nx_s;
        out_data_r <= acc_s[idx_nx_s];
        out_last_r <= (idx_nx_s == IDX_LAST);
      end
    end
  end

endmodule

// File: doc/systolic_mac_array.md
# systolic_mac_array

Parametrised N×N output-stationary systolic matrix-multiply engine, the generalised core behind the 2×2 systolic tile in the `tt_um_*` top level. It computes C = A·B for an N×K by K×N operand pair streamed in one column-of-A / row-of-B beat per cycle, with arbitrary K. It then drains the N×N accumulator grid row-major through a valid/ready output port. The top-level wrapper maps ports onto `ui_in` / `uio_in` / `uo_out`; this block is pin-agnostic.

## Interface
- `N`, 2, array dimension (rows = columns of PEs), ≥2
- `DW`, 8, operand width
- `ACC_W`, 18, accumulator/result width, ≥2·DW
- `SIGNED`, 0, 1 = two's-complement operands and accumulate, 0 = unsigned

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat.
- `a_col` in N·DW: A[i][k] at bits [i·DW +: DW].
- `b_row` in N·DW: B[k][j] at bits [j·DW +: DW].
- `in_last` in 1: marks beat k = K−1.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: consumer accepts the result word.
- `out_data` out ACC_W: C[r][c].
- `out_last` out 1: high with C[N−1][N−1].
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, FEED, DRAIN, READ.
- Beat accepted when `in_valid && in_ready`. `in_ready` = 1 in IDLE and FEED only.
- IDLE → FEED on an accepted beat without `in_last`. IDLE → DRAIN on an accepted beat with `in_last` (K = 1).
- FEED → DRAIN on the accepted beat with `in_last`. FEED holds across bubbles (`in_valid` = 0) indefinitely.
- Skew: row i of A is delayed i extra cycles before PE(i,0). Column j of B is delayed j extra cycles before PE(0,j).
- Each PE passes a right and b down, one register per hop. Each operand carries a valid bit.
- A PE accumulates `acc += a·b` only when its valid bit is set. Bubbles insert valid = 0 and do not disturb accumulators.
- Multiply is DW×DW → 2·DW, extended to ACC_W: sign-extended if SIGNED, else zero-extended.
- Accumulate wraps modulo 2^ACC_W. No saturation, no overflow flag.
- DRAIN: counter runs 2N−1 cycles, then → READ.
- READ: index 0…N²−1 row-major (idx = r·N + c). `out_data` = acc[r][c]. Index advances on `out_valid && out_ready`.
- READ → IDLE on the handshake with `out_last`. All accumulators, skew and PE registers clear on that same edge.

## Timing
- Reset values:
  - state IDLE, `in_ready` = 1.
  - `out_valid`, `out_last`, `busy` = 0; `out_data` = 0.
  - All accumulators, skew, PE data and valid registers = 0; DRAIN counter and read index = 0.
- PE(i,j) accumulates beat k on edge e_k + 1 + i + j, where e_k is the edge accepting beat k.
- `out_valid` rises exactly 2N−1 edges after the edge accepting the `in_last` beat. For N = 2 that is 3 edges.
- `in_ready` falls on the same edge that accepts `in_last`. A beat presented in the next cycle is not accepted.
- `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- One word per cycle under continuous `out_ready`. Total READ length is N² cycles minimum.
- First beat of the next job is accepted no earlier than the cycle after the `out_last` handshake.
- `rst_n` low at any time (mid-FEED, DRAIN or READ) asynchronously forces reset values. The partial job is discarded.
- `in_last` is ignored outside an accepted beat. Inputs are ignored in DRAIN/READ.

## Test plan
- **Basic product.** N=2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]].
  - Beats: `a_col`={3,1}, `b_row`={6,5}; then `a_col`={4,2}, `b_row`={8,7} with `in_last`.
  - Expect `out_data` 19, 22, 43, 50, `out_last` on 50.
  - Expect `out_valid` exactly 3 edges after the last accept.
- **Signed.** SIGNED=1, A=[[−1,0],[0,−1]], B=[[2,3],[4,5]].
  - Expect 0x3FFFE, 0x3FFFD, 0x3FFFC, 0x3FFFB.
- **Wrap.** Unsigned, K=5 beats of all-255 operands.
  - Every word = 325125 mod 2^18 = 62981.
- **Bubbles and backpressure.** Basic product with `in_valid` toggling 1-0-1, plus `out_ready` low for 3 cycles on word 1.
  - Same results; `out_data` held at 22 while stalled.
- **K=1 and back-to-back jobs.**
  - Job 1: single beat A col {1,1}, B row {1,1}. Expect four 1s.
  - Job 2: started the cycle after `out_last`. Results must be unaffected by job 1 (accumulators cleared).
- **Reset mid-operation.** Assert `rst_n` low during DRAIN.
  - All outputs return to reset values immediately.
  - A fresh basic-product job afterwards yields 19, 22, 43, 50.
